// File: rtl/perf_monitor.sv
// Hardware performance monitor: cycle, retired-instruction and event counters
// with saturation, halt freeze and a req/ack readout port.
module perf_monitor #(
  parameter int CNT_W   = 32,
  parameter int LANES   = 1,
  parameter int NUM_EVT = 4,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [LANES-1:0]   commit_vld,
  input  logic               halt,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic               rd_ack,
  output logic [CNT_W-1:0]   rd_data,
  output logic               halted,
  output logic [NUM_EVT+1:0] ovf
);

  localparam int NC = NUM_EVT + 2;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NC];
  logic [CNT_W-1:0]  cnt_d [NC];
  logic [CNT_W:0]    inc   [NC];
  logic [CNT_W:0]    sum   [NC];
  logic [NC-1:0]     ovf_q, ovf_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  sel_val;
  logic              act;

  assign act = en & ~halted_q & ~clr;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      inc[i] = '0;
    end
    inc[0] = (CNT_W+1)'(1);
    for (int l = 0; l < LANES; l++) begin
      inc[1] = inc[1] + (CNT_W+1)'(commit_vld[l]);
    end
    for (int k = 0; k < NUM_EVT; k++) begin
      inc[k+2] = (CNT_W+1)'(evt[k]);
    end
  end

  // One extra bit catches the carry that triggers clamping.
  always_comb begin
    ovf_d    = ovf_q;
    halted_d = halted_q;
    for (int i = 0; i < NC; i++) begin
      sum[i]   = {1'b0, cnt_q[i]} + inc[i];
      cnt_d[i] = cnt_q[i];
      if (act) begin
        if (sum[i][CNT_W]) begin
          cnt_d[i] = '1;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[i][CNT_W-1:0];
        end
      end
    end
    if (act && halt) begin
      halted_d = 1'b1;
    end
    if (clr) begin
      for (int i = 0; i < NC; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d    = '0;
      halted_d = 1'b0;
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NC; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_val = cnt_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          rd_data_d = sel_val;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!rd_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q     <= '0;
      halted_q  <= 1'b0;
      state_q   <= S_IDLE;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q     <= ovf_d;
      halted_q  <= halted_d;
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack  = (state_q == S_ACK);
  assign rd_data = rd_data_q;
  assign halted  = halted_q;
  assign ovf     = ovf_q;

endmodule
